mem_access_unit: RTL and testbench

- Load/store front-end sitting directly upstream of the word-wide data RAM (1-cycle registered-address read, word write, no byte enables).
- Accepts one pipeline memory request at a time and drives the RAM port.
- Performs byte/halfword stores by read-modify-write and sign/zero-extends sub-word loads.
- Returns one response pulse per request and flags misaligned or illegal accesses without touching memory.

---
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end with sub-word read-modify-write and load extension
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif
module mem_access_unit #(
  parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, RD_WAIT = 3'd2, WR = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic we_q, uns_q;
  logic [1:0] size_q, lane_q;
  logic [31:0] wdata_q;
  logic mis, word_st;
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext, mask, merged;
  assign req_ready = state == IDLE;
  // misalignment test on the incoming request, lane extraction/merge on the latched one
  always_comb begin
    mis = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    word_st = req_we && req_size == 2'b10;
    sh = {lane_q, 3'b000};
    b = mem_rdata[sh +: 8];
    h = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    ext = size_q == 2'b00 ? {{24{b[7] & ~uns_q}}, b} : size_q == 2'b01 ? {{16{h[15] & ~uns_q}}, h} : mem_rdata;
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
  end
  // request sequencing: IDLE -> (RD -> RD_WAIT ->) (WR ->) DONE -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_wren <= 1'b0;
      mem_address <= '0;
      mem_write_data <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_misalign <= 1'b0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          size_q <= req_size;
          uns_q <= req_unsigned;
          lane_q <= req_addr[1:0];
          wdata_q <= req_wdata;
          if (mis) begin
            state <= DONE;
            resp_valid <= 1'b1;
            resp_misalign <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state <= word_st ? WR : RD;
            mem_wren <= word_st;
            mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_write_data <= word_st ? req_wdata : mem_write_data;
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: if (we_q) begin
          mem_write_data <= merged;
          mem_wren <= 1'b1;
          state <= WR;
        end else begin
          resp_rdata <= ext;
          resp_misalign <= 1'b0;
          resp_valid <= 1'b1;
          state <= DONE;
        end
        WR: begin
          mem_wren <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_misalign <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_misalign <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests of mem_access_unit against a 1-cycle word RAM model
module tb_mem_access_unit;
  localparam int AW = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_misalign, mem_wren;
  logic [31:0] resp_rdata, mem_write_data, mem_rdata;
  logic [AW-1:0] mem_address;
  logic [31:0] ram [0:63];
  int wren_cnt = 0, resp_cnt = 0, acc_cnt = 0;
  int checks = 0, errors = 0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .mem_wren(mem_wren), .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_wren) ram[mem_address[7:2]] <= mem_write_data;
    mem_rdata <= ram[mem_address[7:2]];
    wren_cnt <= wren_cnt + (mem_wren ? 1 : 0);
    resp_cnt <= resp_cnt + (resp_valid ? 1 : 0);
    acc_cnt <= acc_cnt + ((req_valid && req_ready && !rst) ? 1 : 0);
  end

  task automatic run_req(input logic we, input logic [1:0] sz, input logic un, input logic [AW-1:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic mis,
                         output int wn, output int wat, output logic [31:0] wword, output logic busy_ok);
    int w0;
    @(negedge clk);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    w0 = wren_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_unsigned = ~un; req_addr = '1; req_wdata = '1;
    lat = 0; wat = 0; busy_ok = 1'b1; rd = 'x; mis = 1'bx; wword = 'x;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (req_ready) busy_ok = 1'b0;
      if (mem_wren) begin wat = k; wword = mem_write_data; end
      if (resp_valid) begin lat = k; rd = resp_rdata; mis = resp_misalign; end
    end
    @(negedge clk);
    if (!req_ready) busy_ok = 1'b0;
    wn = wren_cnt - w0;
  endtask

  int lat, wn, wat;
  logic [31:0] rd, ww;
  logic mis, bok;

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if ({mem_wren, resp_valid, resp_misalign} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {mem_wren, resp_valid, resp_misalign}); end
    checks++; if ({mem_address, mem_write_data, resp_rdata} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", mem_address, mem_write_data, resp_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    run_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wst_lat got %0d want 2", lat); end
    checks++; if (wn !== 1 || wat !== 1) begin errors++; $display("FAIL wst_wren got n=%0d at=%0d want n=1 at=1", wn, wat); end
    checks++; if (ww !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_data got %h want deadbeef", ww); end
    checks++; if (rd !== 32'h0 || mis !== 1'b0 || !bok) begin errors++; $display("FAIL wst_resp got rd=%h mis=%b busy_ok=%b want 0/0/1", rd, mis, bok); end
    run_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (lat !== 3 || wn !== 0) begin errors++; $display("FAIL wld_lat got lat=%0d wren=%0d want 3/0", lat, wn); end
    checks++; if (rd !== 32'hDEADBEEF || mis !== 1'b0 || !bok) begin errors++; $display("FAIL wld_data got %h mis=%b busy_ok=%b want deadbeef/0/1", rd, mis, bok); end
  endtask

  task automatic test_rmw;
    run_req(1'b1, 2'b10, 1'b0, 16'h0020, 32'h11223344, lat, rd, mis, wn, wat, ww, bok);
    run_req(1'b1, 2'b00, 1'b0, 16'h0021, 32'h123456AA, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (lat !== 4 || !bok) begin errors++; $display("FAIL bst_lat got %0d busy_ok=%b want 4/1", lat, bok); end
    checks++; if (wn !== 1 || wat !== 3 || ww !== 32'h1122AA44) begin errors++; $display("FAIL bst_write got n=%0d at=%0d %h want 1/3/1122aa44", wn, wat, ww); end
    run_req(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL bst_readback got %h want 1122aa44", rd); end
    run_req(1'b1, 2'b01, 1'b0, 16'h0022, 32'h9999CAFE, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (lat !== 4 || ww !== 32'hCAFEAA44) begin errors++; $display("FAIL hst_write got lat=%0d %h want 4/cafeaa44", lat, ww); end
  endtask

  task automatic test_extend;
    run_req(1'b1, 2'b10, 1'b0, 16'h0030, 32'h80FF7F01, lat, rd, mis, wn, wat, ww, bok);
    run_req(1'b0, 2'b00, 1'b0, 16'h0032, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'hFFFFFFFF || lat !== 3) begin errors++; $display("FAIL lb_s32 got %h lat=%0d want ffffffff/3", rd, lat); end
    run_req(1'b0, 2'b00, 1'b1, 16'h0033, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_33 got %h want 00000080", rd); end
    run_req(1'b0, 2'b01, 1'b0, 16'h0030, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'h00007F01) begin errors++; $display("FAIL lh_30 got %h want 00007f01", rd); end
    run_req(1'b0, 2'b01, 1'b0, 16'h0032, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_32 got %h want ffff80ff", rd); end
    run_req(1'b0, 2'b01, 1'b1, 16'h0032, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'h000080FF) begin errors++; $display("FAIL lhu_32 got %h want 000080ff", rd); end
  endtask

  task automatic test_misalign;
    logic [1:0] szs [3] = '{2'b01, 2'b10, 2'b11};
    logic [AW-1:0] ads [3] = '{16'h0041, 16'h0042, 16'h0040};
    logic wes [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_req(wes[i], szs[i], 1'b0, ads[i], 32'hFFFFFFFF, lat, rd, mis, wn, wat, ww, bok);
      checks++; if (lat !== 1 || mis !== 1'b1 || rd !== 32'h0 || wn !== 0 || !bok) begin
        errors++; $display("FAIL misalign_%0d got lat=%0d mis=%b rd=%h wren=%0d want 1/1/0/0", i, lat, mis, rd, wn);
      end
    end
  endtask

  task automatic test_back_to_back;
    int a0, r0;
    @(negedge clk);
    a0 = acc_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 16'h0010;
    repeat (20) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (acc_cnt - a0 !== 5) begin errors++; $display("FAIL b2b_accepts got %0d want 5", acc_cnt - a0); end
    checks++; if (resp_cnt - r0 !== 5) begin errors++; $display("FAIL b2b_resps got %0d want 5", resp_cnt - r0); end
  endtask

  task automatic test_reset_abort;
    int w0, r0;
    run_req(1'b1, 2'b10, 1'b0, 16'h0050, 32'h12345678, lat, rd, mis, wn, wat, ww, bok);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 16'h0052; req_wdata = 32'h0000BEEF;
    w0 = wren_cnt; r0 = resp_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_wren !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL abort_out got wren=%b resp=%b want 0/0", mem_wren, resp_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready); end
    repeat (4) @(negedge clk);
    checks++; if (wren_cnt !== w0 || resp_cnt !== r0) begin errors++; $display("FAIL abort_quiet got wren+%0d resp+%0d want 0/0", wren_cnt - w0, resp_cnt - r0); end
    run_req(1'b0, 2'b10, 1'b0, 16'h0050, 32'h0, lat, rd, mis, wn, wat, ww, bok);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_mem got %h want 12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_rmw();
    test_extend();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
